// File: rtl/tnn_feature_packer.sv
// tnn_feature_packer: quantizes a stream of raw feature samples into 2-bit
// codes against programmable per-feature thresholds and packs one N_FEAT-code
// vector per frame for the TNN classifier input buses.
module tnn_feature_packer #(
    parameter int N_FEAT = 7,
    parameter int RAW_W  = 8,
    parameter int CODE_W = 2,
    parameter int T0_RST = 64,
    parameter int T1_RST = 128,
    parameter int T2_RST = 192
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [RAW_W-1:0]           s_data,
    input  logic                       s_last,
    input  logic                       cfg_we,
    input  logic [2:0]                 cfg_feat,
    input  logic [1:0]                 cfg_sel,
    input  logic [RAW_W-1:0]           cfg_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_FEAT*CODE_W-1:0]   m_vec,
    output logic                       err_frame,
    output logic [15:0]                frame_cnt
);

    localparam int VEC_W = N_FEAT * CODE_W;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [2:0]       LAST_IDX = 3'(N_FEAT - 1);
    localparam logic [RAW_W-1:0] T0_INIT  = RAW_W'(T0_RST);
    localparam logic [RAW_W-1:0] T1_INIT  = RAW_W'(T1_RST);
    localparam logic [RAW_W-1:0] T2_INIT  = RAW_W'(T2_RST);

    // Thermometer-style code: number of thresholds the sample reaches (0..3),
    // independent of threshold ordering.
    function automatic logic [CODE_W-1:0] quantize(
        input logic [RAW_W-1:0] x,
        input logic [RAW_W-1:0] t0,
        input logic [RAW_W-1:0] t1,
        input logic [RAW_W-1:0] t2
    );
        return CODE_W'(x >= t0) + CODE_W'(x >= t1) + CODE_W'(x >= t2);
    endfunction

    // Delivered-vector counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [0:0]        state_q,     state_d;
    logic [2:0]        idx_q,       idx_d;
    logic [VEC_W-1:0]  shadow_q,    shadow_d;
    logic [VEC_W-1:0]  m_vec_q,     m_vec_d;
    logic              err_q,       err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [RAW_W-1:0]  t0_q [N_FEAT];
    logic [RAW_W-1:0]  t1_q [N_FEAT];
    logic [RAW_W-1:0]  t2_q [N_FEAT];
    logic [RAW_W-1:0]  t0_d [N_FEAT];
    logic [RAW_W-1:0]  t1_d [N_FEAT];
    logic [RAW_W-1:0]  t2_d [N_FEAT];

    logic              accept;
    logic [CODE_W-1:0] code;

    assign s_ready   = (state_q == ST_ACCUM);
    assign m_valid   = (state_q == ST_HOLD);
    assign accept    = s_valid & s_ready;
    assign m_vec     = m_vec_q;
    assign err_frame = err_q;
    assign frame_cnt = frame_cnt_q;

    // Quantize the incoming sample with the current feature's (pre-write) thresholds.
    always_comb begin
        code = quantize(s_data, t0_q[idx_q], t1_q[idx_q], t2_q[idx_q]);
    end

    // Frame assembly, framing checks and output handshake.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        m_vec_d     = m_vec_q;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    shadow_d[idx_q*CODE_W +: CODE_W] = code;
                    if (idx_q == LAST_IDX) begin
                        // Publish including the final code; a missing s_last is flagged
                        // but the vector is still delivered.
                        m_vec_d  = shadow_d;
                        shadow_d = '0;
                        idx_d    = 3'd0;
                        state_d  = ST_HOLD;
                        err_d    = ~s_last;
                    end else if (s_last) begin
                        // Early end of frame: drop the partial vector and resync.
                        shadow_d = '0;
                        idx_d    = 3'd0;
                        err_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                if (m_ready) begin
                    state_d     = ST_ACCUM;
                    frame_cnt_d = sat_inc(frame_cnt_q);
                end
            end
        endcase
    end

    // Threshold register file write port; out-of-range feature/select ignored.
    always_comb begin
        t0_d = t0_q;
        t1_d = t1_q;
        t2_d = t2_q;
        if (cfg_we && (cfg_feat <= LAST_IDX)) begin
            case (cfg_sel)
                2'd0:    t0_d[cfg_feat] = cfg_data;
                2'd1:    t1_d[cfg_feat] = cfg_data;
                2'd2:    t2_d[cfg_feat] = cfg_data;
                default: ;
            endcase
        end
    end

    // State registers; reset restores thresholds and drops any pending vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            idx_q       <= 3'd0;
            shadow_q    <= '0;
            m_vec_q     <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            for (int k = 0; k < N_FEAT; k++) begin
                t0_q[k] <= T0_INIT;
                t1_q[k] <= T1_INIT;
                t2_q[k] <= T2_INIT;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            m_vec_q     <= m_vec_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
        end
    end

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Bench for tnn_feature_packer: table of frames with expected vectors plus
// hand-written sequences for hold, config, framing, saturation and reset.
module tb_tnn_feature_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_last;
    logic [7:0]  s_data;
    logic        cfg_we;
    logic [2:0]  cfg_feat;
    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_data;
    logic        m_valid, m_ready;
    logic [13:0] m_vec;
    logic        err_frame;
    logic [15:0] frame_cnt;

    tnn_feature_packer dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cfg_we(cfg_we), .cfg_feat(cfg_feat), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_vec(m_vec),
        .err_frame(err_frame), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0][7:0] d;
        logic [13:0]     vec;
    } row_t;

    row_t        tab [5];
    logic [13:0] exp_q [$];
    logic [7:0]  tt [7][3];
    logic [15:0] cnt_model;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int f = 0; f < 7; f++) begin
            tt[f][0] = 8'd64;
            tt[f][1] = 8'd128;
            tt[f][2] = 8'd192;
        end
    endtask

    function automatic logic [13:0] model_vec(input logic [6:0][7:0] d);
        logic [13:0] v;
        int c;
        v = '0;
        for (int k = 0; k < 7; k++) begin
            c = 0;
            for (int s = 0; s < 3; s++) if (d[k] >= tt[k][s]) c++;
            v[2*k +: 2] = 2'(c);
        end
        return v;
    endfunction

    task automatic send(input logic [7:0] d, input logic last);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0][7:0] d, input logic last7);
        for (int k = 0; k < 7; k++) send(d[k], (k == 6) ? last7 : 1'b0);
    endtask

    task automatic check_out(input string tag, input logic exp_err);
        chk({tag, "_m_valid"}, m_valid, 1'b1);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_scoreboard: got no expected entry expected one", tag);
        end else begin
            chk({tag, "_m_vec"}, m_vec, exp_q.pop_front());
        end
        chk({tag, "_err_frame"}, err_frame, exp_err);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready   = 1'b0;
        cnt_model = (cnt_model == 16'hFFFF) ? cnt_model : cnt_model + 16'd1;
        chk({tag, "_frame_cnt"}, frame_cnt, cnt_model);
        chk({tag, "_s_ready_after"}, s_ready, 1'b1);
        chk({tag, "_m_valid_after"}, m_valid, 1'b0);
    endtask

    task automatic cfg(input logic [2:0] f, input logic [1:0] sel, input logic [7:0] v);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_feat = f;
        cfg_sel  = sel;
        cfg_data = v;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (f < 3'd7 && sel < 2'd3) tt[f][sel] = v;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [6:0][7:0] d25;
        logic [6:0][7:0] d64;
        d25 = {7{8'd25}};
        d64 = {7{8'd64}};

        tab[0] = '{d: {8'd255, 8'd192, 8'd128, 8'd127, 8'd64, 8'd63, 8'd0},   vec: 14'h3E50};
        tab[1] = '{d: {7{8'd255}},                                             vec: 14'h3FFF};
        tab[2] = '{d: {7{8'd0}},                                               vec: 14'h0000};
        tab[3] = '{d: {8'd255, 8'd192, 8'd191, 8'd128, 8'd127, 8'd64, 8'd63},  vec: 14'h3E94};
        tab[4] = '{d: {8'd128, 8'd255, 8'd0, 8'd50, 8'd150, 8'd100, 8'd200},  vec: 14'h2C27};

        model_reset();
        cnt_model = 16'd0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        cfg_we = 1'b0; cfg_feat = '0; cfg_sel = '0; cfg_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_vec", m_vec, 14'h0);
        chk("rst_err_frame", err_frame, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);

        // Table frames with default thresholds; first one also exercises backpressure.
        for (int r = 0; r < 5; r++) begin
            exp_q.push_back(tab[r].vec);
            send_frame(tab[r].d, 1'b1);
            check_out($sformatf("row%0d", r), 1'b0);
            if (r == 0) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    s_valid = 1'b1;
                    s_data  = 8'hAA;
                    s_last  = 1'b0;
                    @(posedge clk);
                    #1;
                    chk("hold_m_valid", m_valid, 1'b1);
                    chk("hold_s_ready", s_ready, 1'b0);
                    chk("hold_m_vec", m_vec, tab[0].vec);
                end
            end
            handshake($sformatf("row%0d", r));
        end

        // Out-of-range writes, then feature 2 thresholds 10/20/30.
        cfg(3'd7, 2'd0, 8'd0);
        cfg(3'd1, 2'd3, 8'd0);
        cfg(3'd2, 2'd0, 8'd10);
        cfg(3'd2, 2'd1, 8'd20);
        cfg(3'd2, 2'd2, 8'd30);

        // First sample collides with a write to its own threshold: old value applies.
        exp_q.push_back(model_vec(d25));
        @(negedge clk);
        cfg_we = 1'b1; cfg_feat = 3'd0; cfg_sel = 2'd0; cfg_data = 8'd20;
        s_valid = 1'b1; s_data = 8'd25; s_last = 1'b0;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        tt[0][0] = 8'd20;
        for (int k = 1; k < 7; k++) send(8'd25, k == 6);
        check_out("cfg25", 1'b0);
        handshake("cfg25");

        exp_q.push_back(model_vec(d25));
        send_frame(d25, 1'b1);
        check_out("cfg25_new", 1'b0);
        handshake("cfg25_new");

        // Early s_last on the third sample.
        send(8'd10, 1'b0);
        send(8'd200, 1'b0);
        send(8'd255, 1'b1);
        chk("early_err_pulse", err_frame, 1'b1);
        chk("early_no_valid", m_valid, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("early_err_clear", err_frame, 1'b0);
        chk("early_still_no_valid", m_valid, 1'b0);
        exp_q.push_back(model_vec(tab[4].d));
        send_frame(tab[4].d, 1'b1);
        check_out("after_early", 1'b0);
        handshake("after_early");

        // Missing s_last: vector still delivered with an error pulse.
        exp_q.push_back(model_vec(tab[1].d));
        send_frame(tab[1].d, 1'b0);
        check_out("nolast", 1'b1);
        handshake("nolast");
        exp_q.push_back(model_vec(tab[0].d));
        send_frame(tab[0].d, 1'b1);
        check_out("after_nolast", 1'b0);
        handshake("after_nolast");

        // Counter saturation.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        cnt_model = 16'hFFFF;
        chk("sat_preload", frame_cnt, 16'hFFFF);
        exp_q.push_back(model_vec(tab[3].d));
        send_frame(tab[3].d, 1'b1);
        check_out("sat", 1'b0);
        handshake("sat");

        // Asynchronous reset while holding a vector.
        exp_q.push_back(model_vec(d64));
        send_frame(d64, 1'b1);
        check_out("prereset", 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", m_valid, 1'b0);
        chk("arst_s_ready", s_ready, 1'b1);
        chk("arst_frame_cnt", frame_cnt, 16'h0);
        chk("arst_m_vec", m_vec, 14'h0);
        chk("arst_t0_f0", dut.t0_q[0], 8'd64);
        chk("arst_t2_f2", dut.t2_q[2], 8'd192);
        #1;
        rst = 1'b0;
        s_valid = 1'b0;
        model_reset();
        cnt_model = 16'd0;
        exp_q.delete();
        exp_q.push_back(model_vec(d64));
        send_frame(d64, 1'b1);
        check_out("postreset", 1'b0);
        handshake("postreset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tnn_feature_packer.md
Name: tnn_feature_packer

Overview:
- Streaming front end for the 2-bit-per-feature approximate TNN classifiers in the AxLibrary.
- Accepts raw per-feature samples over a valid/ready stream and quantizes each to a 2-bit code using programmable per-feature thresholds.
- Assembles one N_FEAT-code vector per frame and presents it on a valid/ready output that drives the classifier's input_a..input_g buses.
- It is the writer side of the classifier's feature interface.

Parameters:
- N_FEAT, 7, features per frame (vector slot k feeds classifier input k; 0 = input_a)
- RAW_W, 8, raw sample width (unsigned)
- CODE_W, 2, code width per feature (fixed 2; three thresholds per feature)
- T0_RST, 64, reset value of threshold 0 for every feature
- T1_RST, 128, reset value of threshold 1 for every feature
- T2_RST, 192, reset value of threshold 2 for every feature

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  raw sample valid
- s_ready  out  1  packer can accept a sample
- s_data  in  RAW_W  raw feature sample, features arrive in order 0..N_FEAT-1
- s_last  in  1  marks the final sample of a frame
- cfg_we  in  1  threshold write strobe
- cfg_feat  in  3  feature index for the write
- cfg_sel  in  2  threshold select 0..2
- cfg_data  in  RAW_W  threshold value
- m_valid  out  1  packed vector valid
- m_ready  in  1  classifier side accepts the vector
- m_vec  out  N_FEAT*CODE_W  packed codes; feature k occupies bits [2k+1:2k]
- err_frame  out  1  one-cycle pulse on a framing error
- frame_cnt  out  16  count of vectors delivered, saturating at 0xFFFF

Behaviour:
- Reset values:
  - s_ready=1, m_valid=0, m_vec=0, err_frame=0, frame_cnt=0.
  - Feature index=0, state=ACCUM.
  - All thresholds reset to T0_RST/T1_RST/T2_RST.
- Quantization is combinational on s_data: code = (s_data>=t0) + (s_data>=t1) + (s_data>=t2) for the current feature.
  - Unsigned compare.
  - Thresholds need not be ordered; the result is always 0..3.
- State ACCUM:
  - s_ready=1, m_valid=0.
  - On accept (s_valid&s_ready), the code is written into slot[idx] of an internal shadow vector, then idx increments.
- Frame completion:
  - Trigger: accept at idx=N_FEAT-1.
  - The next cycle has m_vec = full shadow vector, including the final code, and m_valid=1.
  - State moves to HOLD and idx returns to 0. Latency from the last accept to m_valid is 1 cycle.
- State HOLD:
  - s_ready=0, and m_vec is stable.
  - When m_valid&m_ready: frame_cnt increments (saturating) and the state returns to ACCUM.
  - s_ready=1 in the cycle after the handshake. There is no same-cycle bypass.
- Framing, s_last early (s_last=1 at idx<N_FEAT-1):
  - The sample is accepted and the partial frame is discarded.
  - err_frame pulses the next cycle, idx returns to 0, and no vector is emitted.
- Framing, s_last missing (s_last=0 at idx=N_FEAT-1):
  - The vector is still emitted normally and err_frame pulses the next cycle, together with m_valid.
  - The following sample starts a new frame.
- Config:
  - A write with cfg_we=1, cfg_feat<N_FEAT and cfg_sel<3 updates the threshold at the clock edge.
  - Out-of-range writes are ignored.
  - If a write and an accept hit the same feature in the same cycle, the sample uses the old threshold.
  - Writes are allowed in any state.
- m_vec is only updated on frame completion. Partial frames never appear on m_vec.
- rst asserted mid-frame or in HOLD: immediately returns all state to reset values. The pending vector and partial frame are lost, and thresholds revert to their reset values.

Test Plan:
- Default thresholds, frame s_data = 0,63,64,127,128,192,255 with s_last on the 7th sample -> 1 cycle later m_valid=1, m_vec=14'b11_11_10_01_01_00_00 (0x3E50), err_frame=0.
- Hold m_ready=0 for 5 cycles after m_valid -> m_vec stable, s_ready=0, s_valid beats not accepted. Then m_ready=1 for 1 cycle -> frame_cnt=1, s_ready=1 on the next cycle.
- Write feature 2 thresholds to 10,20,30, then send all samples = 25 -> slot 2 code=2, other slots code=0. m_vec=0x0020.
- s_last on the 3rd sample -> err_frame pulse, no m_valid. A following clean 7-sample frame emits correctly.
- Assert rst in HOLD with m_valid=1 -> m_valid=0, s_ready=1, frame_cnt=0 and thresholds back to 64/128/192 in the same cycle, without waiting for a clock edge.
- Force frame_cnt to 0xFFFF (or run 65536 frames) and deliver one more vector -> frame_cnt stays 0xFFFF.
